pe_step_ctrl: RTL and testbench
===============================

# pe_step_ctrl

Timestep sequencer for one SNN processing element (`pe`). It accepts one input-spike bitmap per timestep over a valid/ready handshake. It then walks the set bits lowest-index-first, driving `pe_addr`/`accum_en` for one cycle per active input, pulses `spike_done`, and captures the PE's 8-bit result. Each result is returned on a valid/ready output channel with a timestep tag. The block sits between the spike router and a `pe` instance.

## Interface
- `N_IN`, 16: number of input synapses (bitmap width); must equal 2**`ADDR_W`
- `ADDR_W`, 4: width of `pe_addr`
- `OUT_W`, 8: width of `pe_out` / `res_data`
- `clock` input 1: sole clock, rising edge
- `reset_n` input 1: synchronous, active-low reset
- `in_valid` input 1: spike bitmap offered
- `in_ready` output 1: controller accepts bitmap
- `in_spikes` input N_IN: bit i = input i spiked this timestep
- `pe_addr` output ADDR_W: synapse index for the PE
- `accum_en` output 1: PE accumulates weight at `pe_addr`
- `spike_done` output 1: one-cycle end-of-timestep strobe to the PE
- `pe_out` input OUT_W: PE output; valid 1 cycle after `spike_done`
- `res_valid` output 1: result available
- `res_ready` input 1: consumer takes result
- `res_data` output OUT_W: captured `pe_out`
- `res_step` output 8: timestep index of this result
- `res_nspk` output ADDR_W+1: accumulate count for this step (macro-dependent)

## Operation
- FSM states: IDLE, SCAN, FIRE, CAPTURE, RESULT.
- IDLE:
  - `in_ready`=1.
  - On `in_valid`&&`in_ready`, latch `in_spikes` into `pending`.
  - If the bitmap is nonzero, go to SCAN; if zero, go directly to FIRE.
- SCAN, once per cycle:
  - `accum_en`=1 and `pe_addr`=index of the lowest set bit of `pending`.
  - Clear that bit in `pending`.
  - When the bit cleared was the last one, go to FIRE.
- FIRE: `spike_done`=1, `accum_en`=0; go to CAPTURE.
- CAPTURE: sample `pe_out` into `res_data`; go to RESULT.
- RESULT:
  - `res_valid`=1, with `res_data`/`res_step`/`res_nspk` held stable.
  - On `res_ready`, `res_step` increments (wraps 255->0) and the FSM returns to IDLE.
- `pe_addr` holds its last value outside SCAN; `accum_en` and `spike_done` are 0 outside SCAN and FIRE respectively.
- `in_ready`=0 in every state except IDLE. The input is never accepted while a step is in flight.
- Each input index is issued at most once per step, in strictly ascending order.

## Timing
- Reset (`reset_n`=0 at a rising edge), takes effect the next cycle:
  - state=IDLE, `pending`=0, `pe_addr`=0, `accum_en`=0, `spike_done`=0, `res_valid`=0, `res_data`=0, `res_step`=0, `res_nspk`=0.
  - `in_ready`=0 while `reset_n` is low.
- Reset mid-step: abandons the step immediately. No `spike_done` is issued and no result is emitted.
- Input handshake at edge T with k set bits:
  - `accum_en` is high for cycles T+1..T+k.
  - `spike_done` is high at T+k+1.
  - `pe_out` is sampled at the end of T+k+2.
  - `res_valid` rises at T+k+3.
  - For k=0, `spike_done` is high at T+1.
- `res_valid` stays high until `res_ready` is seen; `res_ready` held high gives a one-cycle RESULT. `in_ready` rises the cycle after the result handshake.
- Minimum step period is k+4 cycles.
- All outputs are registered or decoded from state only; there is no combinational path from `in_valid` or `res_ready` to any output.

## Configuration
- `PE_STEP_NSPK_EN` defined:
  - `res_nspk` is a counter, cleared on input handshake and incremented per `accum_en` cycle.
  - It reports popcount(`in_spikes`), 0..N_IN; for an all-ones bitmap it reports 16.
- `PE_STEP_NSPK_EN` undefined: `res_nspk` is tied to 0, the counter is absent, and the port remains.

## Structure
- Package `snn_pkg` holds:
  - the `pe_step_state_t` enum (IDLE, SCAN, FIRE, CAPTURE, RESULT);
  - default localparams `SNN_ADDR_W`=4 and `SNN_OUT_W`=8.
- Sub-module `pe_prio_enc`: combinational lowest-set-bit encoder, N_IN in -> ADDR_W index + `any` flag. The controller instantiates it once on `pending`.

## Test plan
- Bitmap 16'h0000 -> no `accum_en`; `spike_done` at T+1; `res_valid` at T+3 with `res_data`=`pe_out` sampled at T+2; `res_nspk`=0.
- Bitmap 16'h8421 -> `accum_en` for 4 cycles with `pe_addr` 0,5,10,15; `spike_done` at T+5; `res_nspk`=4.
- Bitmap 16'hFFFF, `res_ready` held low 10 cycles -> `pe_addr` 0..15; `res_valid` and `res_data` stable for all 10 cycles; `in_ready`=0 throughout; `res_nspk`=16.
- `in_valid` asserted during SCAN/RESULT -> bitmap not taken. After the result handshake, `in_ready`=1 the next cycle and the step starts.
- 257 back-to-back steps -> `res_step` runs 0..255, 0 (wraps); each step's `spike_done` is exactly one cycle.
- `reset_n` pulsed low during SCAN of 16'h00F0 (after `pe_addr`=5) -> next cycle IDLE; no `spike_done`, no `res_valid`; `res_step`=0; a new step then proceeds normally.

Source files
------------

// File: rtl/snn_pkg.sv
// Shared types and default widths for the SNN processing-element slice.
package snn_pkg;

   typedef enum logic [2:0] {
      IDLE,
      SCAN,
      FIRE,
      CAPTURE,
      RESULT
   } pe_step_state_t;

   localparam int SNN_ADDR_W = 4;
   localparam int SNN_OUT_W  = 8;

endpackage

// File: rtl/pe_step_ctrl_if.sv
// Router/PE/result bundle for pe_step_ctrl.
interface pe_step_ctrl_if
   import snn_pkg::*;
#(
   parameter int N_IN   = 16,
   parameter int ADDR_W = SNN_ADDR_W,
   parameter int OUT_W  = SNN_OUT_W
);

   logic              in_valid;
   logic              in_ready;
   logic [N_IN-1:0]   in_spikes;
   logic [ADDR_W-1:0] pe_addr;
   logic              accum_en;
   logic              spike_done;
   logic [OUT_W-1:0]  pe_out;
   logic              res_valid;
   logic              res_ready;
   logic [OUT_W-1:0]  res_data;
   logic [7:0]        res_step;
   logic [ADDR_W:0]   res_nspk;

   modport master (
      input  in_valid, in_spikes, pe_out, res_ready,
      output in_ready, pe_addr, accum_en, spike_done,
      output res_valid, res_data, res_step, res_nspk
   );

   modport slave (
      output in_valid, in_spikes, pe_out, res_ready,
      input  in_ready, pe_addr, accum_en, spike_done,
      input  res_valid, res_data, res_step, res_nspk
   );

endinterface

// File: rtl/pe_prio_enc.sv
// Lowest-set-bit encoder: index of the first set bit plus an any flag.
module pe_prio_enc
   import snn_pkg::*;
#(
   parameter int N_IN   = 16,
   parameter int ADDR_W = SNN_ADDR_W
) (
   input  logic [N_IN-1:0]   vec,
   output logic [ADDR_W-1:0] idx,
   output logic              any
);

   // Walk downwards so the lowest set bit is the last write.
   always_comb begin
      idx = '0;
      any = 1'b0;
      for (int i = N_IN - 1; i >= 0; i--) begin
         if (vec[i]) begin
            idx = ADDR_W'(i);
            any = 1'b1;
         end
      end
   end

endmodule

// File: rtl/pe_step_ctrl.sv
// Timestep sequencer for one SNN processing element.
// Define PE_STEP_NSPK_EN to build the per-step accumulate counter.
module pe_step_ctrl
   import snn_pkg::*;
#(
   parameter int N_IN   = 16,
   parameter int ADDR_W = SNN_ADDR_W,
   parameter int OUT_W  = SNN_OUT_W
) (
   input  logic           clock,
   input  logic           reset_n,
   pe_step_ctrl_if.master bus
);

   pe_step_state_t    state;
   logic [N_IN-1:0]   pending;
   logic [ADDR_W-1:0] pe_addr_q;
   logic [ADDR_W-1:0] enc_idx;
   logic              enc_any;
   logic              last_bit;
   logic [OUT_W-1:0]  res_data_q;
   logic [7:0]        res_step_q;

   pe_prio_enc #(
      .N_IN   (N_IN),
      .ADDR_W (ADDR_W)
   ) u_enc (
      .vec (pending),
      .idx (enc_idx),
      .any (enc_any)
   );

   // At most one bit left means this SCAN cycle issues the last input.
   assign last_bit = (pending & (pending - N_IN'(1))) == '0;

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state      <= IDLE;
         pending    <= '0;
         pe_addr_q  <= '0;
         res_data_q <= '0;
         res_step_q <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (bus.in_valid) begin
                  pending <= bus.in_spikes;
                  state   <= (bus.in_spikes == '0) ? FIRE : SCAN;
               end
            end
            SCAN: begin
               pending   <= pending & ~(N_IN'(1) << enc_idx);
               pe_addr_q <= enc_idx;
               if (last_bit) state <= FIRE;
            end
            FIRE: state <= CAPTURE;
            CAPTURE: begin
               res_data_q <= bus.pe_out;
               state      <= RESULT;
            end
            RESULT: begin
               if (bus.res_ready) begin
                  res_step_q <= res_step_q + 8'd1;
                  state      <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef PE_STEP_NSPK_EN
   logic [ADDR_W:0] nspk_q;

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         nspk_q <= '0;
      end else if (state == IDLE && bus.in_valid) begin
         nspk_q <= '0;
      end else if (state == SCAN) begin
         nspk_q <= nspk_q + (ADDR_W + 1)'(1);
      end
   end

   assign bus.res_nspk = nspk_q;
`else
   assign bus.res_nspk = '0;
`endif

   // Outputs decode from state and registers only.
   assign bus.in_ready   = reset_n && (state == IDLE);
   assign bus.accum_en   = (state == SCAN) && enc_any;
   assign bus.pe_addr    = (state == SCAN) ? enc_idx : pe_addr_q;
   assign bus.spike_done = (state == FIRE);
   assign bus.res_valid  = (state == RESULT);
   assign bus.res_data   = res_data_q;
   assign bus.res_step   = res_step_q;

endmodule

// File: tb/tb_pe_step_ctrl.sv
// Self-checking bench for pe_step_ctrl: vector table, random steps, reset corner.
module tb_pe_step_ctrl;

   localparam int N_IN   = 16;
   localparam int ADDR_W = 4;
   localparam int OUT_W  = 8;

   logic clock = 1'b0;
   logic reset_n = 1'b0;

   always #5 clock = ~clock;

   pe_step_ctrl_if #(
      .N_IN   (N_IN),
      .ADDR_W (ADDR_W),
      .OUT_W  (OUT_W)
   ) bus ();

   pe_step_ctrl #(
      .N_IN   (N_IN),
      .ADDR_W (ADDR_W),
      .OUT_W  (OUT_W)
   ) dut (
      .clock   (clock),
      .reset_n (reset_n),
      .bus     (bus.master)
   );

   typedef struct {
      logic [15:0] bm;
      int          hold;
      bit          intrude;
      int          exp_k;
      int          exp_first;
      int          exp_last;
      int          exp_sd;
   } vec_t;

   vec_t tbl[8];

   int         checks = 0;
   int         failures = 0;
   logic [7:0] exp_step = 8'd0;
   int         last_addr = 0;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
      end
   endtask

   task automatic tick;
      @(posedge clock);
      #1;
   endtask

   function automatic int exp_nspk(input logic [15:0] bm);
`ifdef PE_STEP_NSPK_EN
      return $countones(bm);
`else
      return 0;
`endif
   endfunction

   // Model: a step issues the set bits in ascending order, one per cycle,
   // then done, capture, and a result held until accepted.
   task automatic run_step(input logic [15:0] bm, input int hold,
                           input bit intrude, output int obs_k,
                           output int obs_first, output int obs_last,
                           output int obs_sd);
      int         addrs[$];
      int         k;
      logic [7:0] exp_data;
      bit         done;
      for (int i = 0; i < 16; i++) if (bm[i]) addrs.push_back(i);
      k         = addrs.size();
      obs_k     = 0;
      obs_first = -1;
      obs_last  = -1;
      obs_sd    = -1;
      exp_data  = 8'h00;
      done      = 1'b0;
      chk("in_ready_idle", 32'(bus.in_ready), 32'd1);
      bus.in_valid  = 1'b1;
      bus.in_spikes = bm;
      tick;
      bus.in_valid  = intrude;
      bus.in_spikes = ~bm;
      for (int j = 1; j <= k + hold + 12 && !done; j++) begin
         bus.pe_out = 8'($urandom);
         chk("in_ready_busy", 32'(bus.in_ready), 32'd0);
         chk("accum_en", 32'(bus.accum_en), 32'(j <= k));
         chk("spike_done", 32'(bus.spike_done), 32'(j == k + 1));
         if (bus.accum_en === 1'b1) begin
            obs_k++;
            if (obs_first < 0) obs_first = int'(bus.pe_addr);
            obs_last = int'(bus.pe_addr);
         end
         if (bus.spike_done === 1'b1 && obs_sd < 0) obs_sd = j;
         if (j <= k) begin
            chk("pe_addr", 32'(bus.pe_addr), 32'(addrs[j-1]));
            last_addr = addrs[j-1];
         end else begin
            chk("pe_addr_hold", 32'(bus.pe_addr), 32'(last_addr));
         end
         if (j == k + 2) exp_data = bus.pe_out;
         chk("res_valid", 32'(bus.res_valid), 32'(j >= k + 3));
         if (j >= k + 3) begin
            chk("res_data", 32'(bus.res_data), 32'(exp_data));
            chk("res_step", 32'(bus.res_step), 32'(exp_step));
            chk("res_nspk", 32'(bus.res_nspk), 32'(exp_nspk(bm)));
            bus.res_ready = (j - (k + 3)) >= hold;
            if (bus.res_ready) done = 1'b1;
         end
         tick;
      end
      bus.res_ready = 1'b0;
      bus.in_valid  = 1'b0;
      if (!done) begin
         checks++;
         failures++;
         $display("FAIL result_timeout actual=none expected=handshake bm=%h", bm);
      end else begin
         exp_step++;
         chk("in_ready_after", 32'(bus.in_ready), 32'd1);
         chk("res_valid_after", 32'(bus.res_valid), 32'd0);
      end
   endtask

   initial begin : main
      int         ok;
      int         of;
      int         ol;
      int         osd;
      logic [15:0] bm;

      tbl[0] = '{16'h0000, 0,  1'b0, 0,  -1, -1, 1};
      tbl[1] = '{16'h8421, 1,  1'b0, 4,  0,  15, 5};
      tbl[2] = '{16'hFFFF, 10, 1'b1, 16, 0,  15, 17};
      tbl[3] = '{16'h00F0, 0,  1'b1, 4,  4,  7,  5};
      tbl[4] = '{16'h8000, 2,  1'b0, 1,  15, 15, 2};
      tbl[5] = '{16'h0001, 0,  1'b0, 1,  0,  0,  2};
      tbl[6] = '{16'h0000, 3,  1'b1, 0,  -1, -1, 1};
      tbl[7] = '{16'hAAAA, 0,  1'b0, 8,  1,  15, 9};

      bus.in_valid  = 1'b0;
      bus.in_spikes = '0;
      bus.res_ready = 1'b0;
      bus.pe_out    = '0;

      reset_n = 1'b0;
      repeat (3) tick;
      chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
      chk("rst_accum_en", 32'(bus.accum_en), 32'd0);
      chk("rst_spike_done", 32'(bus.spike_done), 32'd0);
      chk("rst_res_valid", 32'(bus.res_valid), 32'd0);
      chk("rst_res_data", 32'(bus.res_data), 32'd0);
      chk("rst_res_step", 32'(bus.res_step), 32'd0);
      chk("rst_res_nspk", 32'(bus.res_nspk), 32'd0);
      chk("rst_pe_addr", 32'(bus.pe_addr), 32'd0);
      reset_n = 1'b1;
      tick;

      for (int v = 0; v < 8; v++) begin
         run_step(tbl[v].bm, tbl[v].hold, tbl[v].intrude, ok, of, ol, osd);
         chk("tbl_count", 32'(ok), 32'(tbl[v].exp_k));
         chk("tbl_first", 32'(of), 32'(tbl[v].exp_first));
         chk("tbl_last", 32'(ol), 32'(tbl[v].exp_last));
         chk("tbl_sdone", 32'(osd), 32'(tbl[v].exp_sd));
      end

      for (int r = 0; r < 30; r++) begin
         bm = 16'($urandom);
         if (r % 3 == 0) bm = bm & 16'($urandom);
         run_step(bm, int'($urandom_range(0, 3)), 1'($urandom), ok, of, ol, osd);
      end

      // Reset while the controller is mid-scan of 16'h00F0.
      chk("mid_in_ready", 32'(bus.in_ready), 32'd1);
      bus.in_valid  = 1'b1;
      bus.in_spikes = 16'h00F0;
      tick;
      bus.in_valid = 1'b0;
      chk("mid_addr4", 32'(bus.pe_addr), 32'd4);
      tick;
      chk("mid_addr5", 32'(bus.pe_addr), 32'd5);
      reset_n = 1'b0;
      tick;
      chk("mid_rst_in_ready", 32'(bus.in_ready), 32'd0);
      chk("mid_rst_accum", 32'(bus.accum_en), 32'd0);
      chk("mid_rst_sdone", 32'(bus.spike_done), 32'd0);
      chk("mid_rst_valid", 32'(bus.res_valid), 32'd0);
      chk("mid_rst_step", 32'(bus.res_step), 32'd0);
      chk("mid_rst_addr", 32'(bus.pe_addr), 32'd0);
      reset_n = 1'b1;
      for (int c = 0; c < 4; c++) begin
         tick;
         chk("post_rst_sdone", 32'(bus.spike_done), 32'd0);
         chk("post_rst_valid", 32'(bus.res_valid), 32'd0);
         chk("post_rst_accum", 32'(bus.accum_en), 32'd0);
         chk("post_rst_in_ready", 32'(bus.in_ready), 32'd1);
      end
      exp_step  = 8'd0;
      last_addr = 0;

      // 257 back-to-back steps: res_step covers 0..255 then wraps to 0.
      for (int s = 0; s < 257; s++) begin
         bm = 16'($urandom) & 16'($urandom);
         run_step(bm, 0, 1'b0, ok, of, ol, osd);
         chk("b2b_count", 32'(ok), 32'($countones(bm)));
      end
      chk("wrap_step", 32'(bus.res_step), 32'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
